// File: rtl/yuv_color_tracker_if.sv
// Camera byte bus into the tracker and frame-memory write port out of it.
interface yuv_color_tracker_if #(
   parameter int unsigned ADDR_W = 20
) ();
   logic              href;
   logic              vsync;
   logic [7:0]        byte_camera;
   logic              enable_write_memory;
   logic [ADDR_W-1:0] pos_pxl;
   logic [7:0]        pixel_out;

   modport master (
      output href, vsync, byte_camera,
      input  enable_write_memory, pos_pxl, pixel_out
   );

   modport slave (
      input  href, vsync, byte_camera,
      output enable_write_memory, pos_pxl, pixel_out
   );
endinterface

// File: rtl/yuv_color_tracker.sv
// YCbCr 4:2:2 capture, per-pixel colour classification, run detection and frame results.
// Define TRACKER_BBOX_EN to build the per-frame bounding-box tracker.
module yuv_color_tracker #(
   parameter int unsigned H_RES   = 640,
   parameter int unsigned V_RES   = 480,
   parameter int unsigned ADDR_W  = 20,
   parameter int unsigned CB_MIN  = 139,
   parameter int unsigned CR_MIN  = 145,
   parameter int unsigned Y_MIN   = 40,
   parameter int unsigned RUN_LEN = 8
) (
   input  logic                pclk,
   input  logic                reset,
   yuv_color_tracker_if.slave  cam,
   output logic                achou_out,
   output logic [ADDR_W-1:0]   detect_pos_pixel,
   output logic                frame_done,
   output logic                overflow,
   output logic [15:0]         bbox_xmin,
   output logic [15:0]         bbox_xmax,
   output logic [15:0]         bbox_ymin,
   output logic [15:0]         bbox_ymax
);
   localparam int unsigned AW1 = ADDR_W + 1;
   // One extra bit so the pixel limit is representable even when 2^ADDR_W == H_RES*V_RES.
   localparam logic [ADDR_W:0] NPIX   = AW1'(H_RES * V_RES);
   localparam logic [7:0]      CB_TH  = 8'(CB_MIN);
   localparam logic [7:0]      CR_TH  = 8'(CR_MIN);
   localparam logic [7:0]      Y_TH   = 8'(Y_MIN);
   localparam logic [7:0]      RUN_TH = 8'(RUN_LEN);

   logic [1:0]        phase_q;
   logic [7:0]        cb_q, y0_q, cr_q;
   logic              href_q;
   logic [2:0]        vs_q;
   logic [ADDR_W:0]   addr_q;
   logic [7:0]        run_q, run_d;
   logic              found_q, found_d;
   logic [ADDR_W-1:0] found_pos_q, found_pos_d;

   logic       href_fall, vs_edge, is_pix, room, emit, match, hit;
   logic [7:0] pix_y, pix_cr, pix_d;

   assign href_fall = href_q & ~cam.href;
   assign vs_edge   = vs_q[1] & ~vs_q[2];
   // Phase 2 pairs Cr with stored Y0; phase 3 pairs stored Cr with incoming Y1.
   assign pix_y     = phase_q[0] ? cam.byte_camera : y0_q;
   assign pix_cr    = phase_q[0] ? cr_q : cam.byte_camera;
   assign match     = (cb_q > CB_TH) && (pix_cr > CR_TH) && (pix_y > Y_TH);
   assign is_pix    = cam.href & phase_q[1];
   assign room      = (addr_q != NPIX);
   assign emit      = is_pix & room;

   always_comb begin
      run_d       = run_q;
      found_d     = found_q;
      found_pos_d = found_pos_q;
      hit         = 1'b0;
      if (href_fall) run_d = '0;
      if (emit) begin
         if (match) run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
         else       run_d = '0;
         hit = match && (run_d == RUN_TH) && !found_q;
         if (hit) begin
            found_d     = 1'b1;
            found_pos_d = addr_q[ADDR_W-1:0];
         end
      end
      if (!match)   pix_d = {1'b0, pix_y[7:1]};
      else if (hit) pix_d = 8'hFE;
      else          pix_d = 8'hFF;
   end

   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         phase_q                 <= '0;
         cb_q                    <= '0;
         y0_q                    <= '0;
         cr_q                    <= '0;
         href_q                  <= 1'b0;
         vs_q                    <= '0;
         addr_q                  <= '0;
         run_q                   <= '0;
         found_q                 <= 1'b0;
         found_pos_q             <= '0;
         cam.enable_write_memory <= 1'b0;
         cam.pos_pxl             <= '0;
         cam.pixel_out           <= '0;
         achou_out               <= 1'b0;
         detect_pos_pixel        <= '0;
         frame_done              <= 1'b0;
         overflow                <= 1'b0;
      end else begin
         phase_q <= cam.href ? phase_q + 2'd1 : 2'd0;
         href_q  <= cam.href;
         vs_q    <= {vs_q[1:0], cam.vsync};
         if (cam.href && phase_q == 2'd0) cb_q <= cam.byte_camera;
         if (cam.href && phase_q == 2'd1) y0_q <= cam.byte_camera;
         if (cam.href && phase_q == 2'd2) cr_q <= cam.byte_camera;

         cam.enable_write_memory <= emit;
         if (emit) begin
            cam.pos_pxl   <= addr_q[ADDR_W-1:0];
            cam.pixel_out <= pix_d;
         end

         frame_done  <= vs_edge;
         found_pos_q <= found_pos_d;
         // A coincident emit is already folded into found_d, so it lands in the ending frame.
         if (vs_edge) begin
            achou_out <= found_d;
            if (found_d) detect_pos_pixel <= found_pos_d;
            addr_q   <= '0;
            run_q    <= '0;
            found_q  <= 1'b0;
            overflow <= 1'b0;
         end else begin
            if (emit) addr_q <= addr_q + AW1'(1);
            run_q   <= run_d;
            found_q <= found_d;
            if (is_pix && !room) overflow <= 1'b1;
         end
      end
   end

`ifdef TRACKER_BBOX_EN
   logic [15:0] x_q, y_q, xmin_q, xmax_q, ymin_q, ymax_q;
   logic [15:0] xmin_d, xmax_d, ymin_d, ymax_d;

   always_comb begin
      xmin_d = xmin_q;
      xmax_d = xmax_q;
      ymin_d = ymin_q;
      ymax_d = ymax_q;
      if (emit && match) begin
         if (x_q < xmin_q) xmin_d = x_q;
         if (x_q > xmax_q) xmax_d = x_q;
         if (y_q < ymin_q) ymin_d = y_q;
         if (y_q > ymax_q) ymax_d = y_q;
      end
   end

   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         x_q       <= '0;
         y_q       <= '0;
         xmin_q    <= '1;
         xmax_q    <= '0;
         ymin_q    <= '1;
         ymax_q    <= '0;
         bbox_xmin <= '0;
         bbox_xmax <= '0;
         bbox_ymin <= '0;
         bbox_ymax <= '0;
      end else if (vs_edge) begin
         bbox_xmin <= xmin_d;
         bbox_xmax <= xmax_d;
         bbox_ymin <= ymin_d;
         bbox_ymax <= ymax_d;
         x_q       <= '0;
         y_q       <= '0;
         xmin_q    <= '1;
         xmax_q    <= '0;
         ymin_q    <= '1;
         ymax_q    <= '0;
      end else begin
         xmin_q <= xmin_d;
         xmax_q <= xmax_d;
         ymin_q <= ymin_d;
         ymax_q <= ymax_d;
         if (href_fall) begin
            x_q <= '0;
            y_q <= y_q + 16'd1;
         end else if (emit) begin
            x_q <= x_q + 16'd1;
         end
      end
   end
`else
   assign bbox_xmin = '0;
   assign bbox_xmax = '0;
   assign bbox_ymin = '0;
   assign bbox_ymax = '0;
`endif
endmodule

// File: doc/yuv_color_tracker.md
# yuv_color_tracker

Parametrised camera front-end that captures YCbCr 4:2:2 bytes from the sensor bus, classifies every pixel against configurable Cb/Cr/Y thresholds, and streams 8-bit grey/marker pixels with frame-buffer write addresses to the memory block. It tracks runs of matching pixels per line, latches the first detection position per frame, and publishes per-frame results at frame end. It replaces the fixed 640x480 capture stage between the camera pins and the frame memory.

## Interface
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- ADDR_W, 20, write address width; must satisfy 2^ADDR_W >= H_RES*V_RES
- CB_MIN, 139, match when Cb > CB_MIN
- CR_MIN, 145, match when Cr > CR_MIN
- Y_MIN, 40, match when Y > Y_MIN
- RUN_LEN, 8, consecutive matches that constitute a detection (1..255)

- pclk  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- href  in  1  line valid; bytes sampled while high
- vsync  in  1  frame sync; rising edge marks frame end
- byte_camera  in  8  sensor data, order Cb,Y0,Cr,Y1
- enable_write_memory  out  1  one-cycle write strobe per pixel
- pos_pxl  out  ADDR_W  write address of pixel_out
- pixel_out  out  8  output pixel
- achou_out  out  1  detection in last completed frame
- detect_pos_pixel  out  ADDR_W  address of detection in last completed frame
- frame_done  out  1  one-cycle pulse when results update
- overflow  out  1  sticky: frame exceeded H_RES*V_RES pixels; cleared at frame end
- bbox_xmin, bbox_xmax  out  16  column extent of matches, last frame
- bbox_ymin, bbox_ymax  out  16  line extent of matches, last frame

## Operation
- Reset (reset=0): all outputs 0; phase=0, x=0, y=0, addr=0, run=0, found=0; bbox trackers to empty (min=all-ones, max=0).
- Byte phase counter 0..3 advances each pclk while href=1; forced to 0 while href=0. A partial group at href fall is discarded.
- Phase 0 stores Cb, phase 1 stores Y0. Phase 2 (Cr byte): classify pixel0 from stored Cb, Y0 and incoming Cr; emit. Phase 3 (Y1 byte): classify pixel1 from stored Cb, stored Cr, incoming Y1; emit.
- Emit: enable_write_memory=1, pos_pxl=addr, addr+=1, x+=1. Match -> pixel_out=8'hFF; else pixel_out=Y>>1 (Y of that pixel).
- Run counter: match -> run+1 (saturating at 255); non-match or line start -> 0. When a match makes run==RUN_LEN and found=0: pixel_out=8'hFE, found=1, found_pos=that pixel's address.
- href falling edge: y+=1, x=0, run=0.
- Emit while addr==H_RES*V_RES: suppressed (enable_write_memory=0), overflow=1.
- vsync rising edge: achou_out=found; detect_pos_pixel=found_pos if found else unchanged; bbox outputs loaded; frame_done=1 for one cycle; addr, x, y, run, found, trackers cleared.
- vsync edge coincident with an emit: the emit completes into the ending frame, then frame-end clear applies.

## Timing
- Pixel outputs registered on the same edge that samples the Cr / Y1 byte: two writes per four pclk, at phases 2 and 3.
- enable_write_memory high exactly one cycle per emitted pixel; pixel_out and pos_pxl hold between strobes.
- Detection-to-result latency: until next vsync rising edge + 1 pclk (vsync sampled through 2-flop sync; edge detected on 3rd flop).
- Asynchronous reset mid-line: immediate clear; capture resumes at next href rise with phase 0.

## Configuration
- TRACKER_BBOX_EN defined: per-frame min/max column and line of every matching pixel tracked and published at frame end; frame with no matches publishes xmin=ymin=16'hFFFF, xmax=ymax=0.
- Undefined: tracker logic absent; bbox outputs tied to 0.

## Test plan
- Reset 0 with href toggling -> all outputs 0, no write strobes.
- One line of 4 groups Cb=0x80,Y0=0x60,Cr=0x80,Y1=0x20 -> 8 strobes, pos_pxl 0..7, pixel_out alternating 0x30,0x10.
- Groups Cb=0x90,Y=0x50,Cr=0xA0 (all match), RUN_LEN=8 -> pixels 0..6 = 0xFF, pixel 7 = 0xFE; after vsync achou_out=1, detect_pos_pixel=7, frame_done one pulse.
- 7 matches, 1 non-match, 7 matches -> no 0xFE; achou_out=0 after vsync; run also broken across href low.
- H_RES=4,V_RES=2, 3 lines of data -> 8 strobes, remainder suppressed, overflow=1, cleared after vsync; next frame starts at pos_pxl 0.
- TRACKER_BBOX_EN, matches only at (x=2,y=1) and (x=5,y=3) -> bbox 2,5,1,3; without macro -> all 0.
